dmem_arbiter: RTL and testbench



---
 rtl/dmem_arbiter_if.sv | 27 ++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 tb/tb_dmem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
// Requester-side bus of the data-memory arbiter.
// One instance per requester port.
//   master modport: the requester drives req/we/addr/wdata and receives gnt/rvalid/rdata.
//   slave modport:  the arbiter's view of the same signals.
// Signals:
//   req    access request, held with we/addr/wdata until gnt is seen
//   we     1 = write, 0 = read
//   addr   memory address
//   wdata  write data
//   gnt    access accepted this cycle (combinational)
//   rvalid read data valid, one-cycle pulse per accepted read
//   rdata  read data, holds its last value while rvalid is low
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              gnt;
  logic              rvalid;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data memory.
// Port 0 (processor) has fixed priority; port 1 (debug/loader) takes priority once it has
// been denied STARVE_LIMIT consecutive cycles. Reads are tracked through a READ_LAT-deep
// pipeline so the returning mem_q is steered to the port that issued the read.
// Ports:
//   clock, reset       single clock, synchronous active-high reset
//   m0, m1             requester buses (dmem_arbiter_if.slave)
//   mem_address/data   address and write data to the memory, zero when idle
//   mem_wren           memory write enable
//   mem_q              memory read data, valid READ_LAT cycles after the address
//   stat_gnt0/1        grant counters per port       (only with DMEM_ARB_STATS_EN)
//   stat_conflict      cycles with both requests high (only with DMEM_ARB_STATS_EN)
// Optional feature macro: DMEM_ARB_STATS_EN adds the saturating statistics counters.
module dmem_arbiter #(
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned READ_LAT     = 1,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     m0,
  dmem_arbiter_if.slave     m1,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_wren,
  input  logic [DATA_W-1:0] mem_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_gnt0,
  output logic [15:0]       stat_gnt1,
  output logic [15:0]       stat_conflict
`endif
);

  logic [3:0]          starve_cnt_q, starve_cnt_d;
  logic                starved;
  logic                gnt0, gnt1, gnt_read;
  logic [READ_LAT-1:0] pipe_valid_q, pipe_owner_q;
  logic                ret_valid, ret_owner;
  logic [DATA_W-1:0]   rdata0_q, rdata1_q;

  assign starved = (32'(starve_cnt_q) >= STARVE_LIMIT);

  // Grants are suppressed during reset so a held request is only arbitrated afterwards.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!reset) begin
      if (m1.req && (!m0.req || starved)) begin
        gnt1 = 1'b1;
      end else if (m0.req) begin
        gnt0 = 1'b1;
      end
    end
  end

  assign m0.gnt   = gnt0;
  assign m1.gnt   = gnt1;
  assign gnt_read = (gnt0 && !m0.we) || (gnt1 && !m1.we);

  always_comb begin
    mem_address = '0;
    mem_data    = '0;
    mem_wren    = 1'b0;
    if (gnt0) begin
      mem_address = m0.addr;
      mem_data    = m0.wdata;
      mem_wren    = m0.we;
    end else if (gnt1) begin
      mem_address = m1.addr;
      mem_data    = m1.wdata;
      mem_wren    = m1.we;
    end
  end

  always_comb begin
    starve_cnt_d = 4'd0;
    if (m1.req && !gnt1) begin
      starve_cnt_d = (starve_cnt_q == 4'hF) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      starve_cnt_q <= 4'd0;
      pipe_valid_q <= '0;
      pipe_owner_q <= '0;
    end else begin
      starve_cnt_q    <= starve_cnt_d;
      pipe_valid_q[0] <= gnt_read;
      pipe_owner_q[0] <= gnt1;
      for (int i = 1; i < int'(READ_LAT); i++) begin
        pipe_valid_q[i] <= pipe_valid_q[i-1];
        pipe_owner_q[i] <= pipe_owner_q[i-1];
      end
    end
  end

  // Gating with reset drops any read still in flight when reset arrives.
  assign ret_valid = pipe_valid_q[READ_LAT-1] && !reset;
  assign ret_owner = pipe_owner_q[READ_LAT-1];
  assign m0.rvalid = ret_valid && !ret_owner;
  assign m1.rvalid = ret_valid && ret_owner;

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if (m0.rvalid) rdata0_q <= mem_q;
      if (m1.rvalid) rdata1_q <= mem_q;
    end
  end

  // Returned data passes straight through in the rvalid cycle, then is held.
  assign m0.rdata = reset ? '0 : (m0.rvalid ? mem_q : rdata0_q);
  assign m1.rdata = reset ? '0 : (m1.rvalid ? mem_q : rdata1_q);

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_gnt0     <= '0;
      stat_gnt1     <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt0 && stat_gnt0 != 16'hFFFF) stat_gnt0 <= stat_gnt0 + 16'd1;
      if (gnt1 && stat_gnt1 != 16'hFFFF) stat_gnt1 <= stat_gnt1 + 16'd1;
      if (m0.req && m1.req && stat_conflict != 16'hFFFF) begin
        stat_conflict <= stat_conflict + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter. Two instances run in lockstep on identical stimulus:
// dut_a with READ_LAT=1 and dut_b with READ_LAT=2, each with its own memory model.
// Expected read returns are queued when a read grant is expected and popped by a
// negedge monitor in the cycle the return is due.
module tb_dmem_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) ia0 ();
  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) ia1 ();
  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) ib0 ();
  dmem_arbiter_if #(.ADDR_W(12), .DATA_W(32)) ib1 ();

  logic [11:0] addr_a, addr_b;
  logic [31:0] data_a, data_b, q_a, q_b, qb1;
  logic        wren_a, wren_b;
`ifdef DMEM_ARB_STATS_EN
  logic [15:0] sa_g0, sa_g1, sa_c, sb_g0, sb_g1, sb_c;
`endif

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LAT(1), .STARVE_LIMIT(4)) dut_a (
    .clock(clock), .reset(reset), .m0(ia0), .m1(ia1),
    .mem_address(addr_a), .mem_data(data_a), .mem_wren(wren_a), .mem_q(q_a)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(sa_g0), .stat_gnt1(sa_g1), .stat_conflict(sa_c)
`endif
  );

  dmem_arbiter #(.ADDR_W(12), .DATA_W(32), .READ_LAT(2), .STARVE_LIMIT(4)) dut_b (
    .clock(clock), .reset(reset), .m0(ib0), .m1(ib1),
    .mem_address(addr_b), .mem_data(data_b), .mem_wren(wren_b), .mem_q(q_b)
`ifdef DMEM_ARB_STATS_EN
    , .stat_gnt0(sb_g0), .stat_gnt1(sb_g1), .stat_conflict(sb_c)
`endif
  );

  // Power-on memory contents; 0x010 holds DEADBEEF.
  function automatic logic [31:0] init_val(input logic [11:0] a);
    return (a == 12'h010) ? 32'hDEADBEEF : {20'hA5A5A, a};
  endfunction

  logic [31:0] mem_a [4096];
  logic [31:0] mem_b [4096];
  bit          wr_a  [4096];
  bit          wr_b  [4096];
  logic [31:0] ref_mem [4096];

  always @(posedge clock) begin
    if (wren_a) begin
      mem_a[addr_a] <= data_a;
      wr_a[addr_a]  <= 1'b1;
    end
    q_a <= wr_a[addr_a] ? mem_a[addr_a] : init_val(addr_a);
  end

  always @(posedge clock) begin
    if (wren_b) begin
      mem_b[addr_b] <= data_b;
      wr_b[addr_b]  <= 1'b1;
    end
    qb1 <= wr_b[addr_b] ? mem_b[addr_b] : init_val(addr_b);
    q_b <= qb1;
  end

  typedef struct {
    int          due;
    logic        port;
    logic [31:0] data;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea, eb;

  // Scoreboard monitor: every cycle either the due return appears on exactly its port, or
  // no rvalid at all.
  always @(negedge clock) begin
    checks++;
    if (qa.size() > 0 && qa[0].due <= cyc) begin
      ea = qa.pop_front();
      if ({ia0.rvalid, ia1.rvalid} !== (ea.port ? 2'b01 : 2'b10) ||
          (ea.port ? ia1.rdata : ia0.rdata) !== ea.data)
      begin
        errors++;
        $display("FAIL lat1_return cyc=%0d port=%0d rvalid=%b rdata=%h required rdata=%h",
                 cyc, ea.port, {ia0.rvalid, ia1.rvalid}, ea.port ? ia1.rdata : ia0.rdata,
                 ea.data);
      end
    end else if ({ia0.rvalid, ia1.rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL lat1_spurious_rvalid cyc=%0d rvalid=%b required 00", cyc,
               {ia0.rvalid, ia1.rvalid});
    end
    checks++;
    if (qb.size() > 0 && qb[0].due <= cyc) begin
      eb = qb.pop_front();
      if ({ib0.rvalid, ib1.rvalid} !== (eb.port ? 2'b01 : 2'b10) ||
          (eb.port ? ib1.rdata : ib0.rdata) !== eb.data)
      begin
        errors++;
        $display("FAIL lat2_return cyc=%0d port=%0d rvalid=%b rdata=%h required rdata=%h",
                 cyc, eb.port, {ib0.rvalid, ib1.rvalid}, eb.port ? ib1.rdata : ib0.rdata,
                 eb.data);
      end
    end else if ({ib0.rvalid, ib1.rvalid} !== 2'b00) begin
      errors++;
      $display("FAIL lat2_spurious_rvalid cyc=%0d rvalid=%b required 00", cyc,
               {ib0.rvalid, ib1.rvalid});
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_port(input bit p, input logic r, input logic w, input logic [11:0] a,
                          input logic [31:0] d);
    if (!p) begin
      ia0.req = r; ia0.we = w; ia0.addr = a; ia0.wdata = d;
      ib0.req = r; ib0.we = w; ib0.addr = a; ib0.wdata = d;
    end else begin
      ia1.req = r; ia1.we = w; ia1.addr = a; ia1.wdata = d;
      ib1.req = r; ib1.we = w; ib1.addr = a; ib1.wdata = d;
    end
  endtask

  // Queue the expected return of a read granted in the current cycle.
  task automatic push_read(input bit p, input logic [11:0] a);
    qa.push_back('{due: cyc + 1, port: p, data: ref_mem[a]});
    qb.push_back('{due: cyc + 2, port: p, data: ref_mem[a]});
  endtask

  task automatic test_reset();
    tick();
    reset = 1'b1;
    qa.delete();
    qb.delete();
    set_port(0, 1'b1, 1'b0, 12'h010, 32'h0);
    set_port(1, 1'b1, 1'b1, 12'h020, 32'hFFFF);
    @(negedge clock);
    checks++;
    if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_gnt got=%b required 0000", {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt});
    end
    checks++;
    if ({wren_a, wren_b, addr_a, addr_b, data_a, data_b} !== '0) begin
      errors++;
      $display("FAIL reset_mem_outputs wren=%b%b addr=%h/%h data=%h/%h required all 0",
               wren_a, wren_b, addr_a, addr_b, data_a, data_b);
    end
    tick();
    set_port(0, 1'b0, 1'b0, 12'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({ia0.rdata, ia1.rdata, ib0.rdata, ib1.rdata} !== '0) begin
      errors++;
      $display("FAIL reset_rdata got=%h %h %h %h required 0", ia0.rdata, ia1.rdata,
               ib0.rdata, ib1.rdata);
    end
  endtask

  task automatic test_single_read();
    tick();
    set_port(0, 1'b1, 1'b0, 12'h010, 32'h0);
    @(negedge clock);
    checks++;
    if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt} !== 4'b1010) begin
      errors++;
      $display("FAIL single_read_gnt got=%b required 1010", {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt});
    end
    checks++;
    if ({addr_a, addr_b, wren_a, wren_b} !== {12'h010, 12'h010, 2'b00}) begin
      errors++;
      $display("FAIL single_read_mem addr=%h/%h wren=%b%b required 010/010 00",
               addr_a, addr_b, wren_a, wren_b);
    end
    push_read(0, 12'h010);
    tick();
    set_port(0, 1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    tick();
    @(negedge clock);
    checks++;
    if ({ia0.rdata, ib0.rdata} !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
      errors++;
      $display("FAIL rdata_hold got=%h/%h required DEADBEEF", ia0.rdata, ib0.rdata);
    end
  endtask

  task automatic test_starvation();
    bit exp1;
    test_reset();
    for (int i = 0; i < 10; i++) begin
      tick();
      set_port(0, 1'b1, 1'b0, 12'h003, 32'h0);
      set_port(1, 1'b1, 1'b0, 12'h002, 32'h0);
      @(negedge clock);
      exp1 = (i % 5 == 4);
      checks++;
      if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt} !== {!exp1, exp1, !exp1, exp1}) begin
        errors++;
        $display("FAIL starve_gnt cycle=%0d got=%b required %b", i,
                 {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt}, {!exp1, exp1, !exp1, exp1});
      end
      push_read(exp1, exp1 ? 12'h002 : 12'h003);
    end
    tick();
    set_port(0, 1'b0, 1'b0, 12'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 12'h0, 32'h0);
`ifdef DMEM_ARB_STATS_EN
    @(negedge clock);
    checks++;
    if ({sa_g0, sa_g1, sa_c, sb_g0, sb_g1, sb_c} !==
        {16'd8, 16'd2, 16'd10, 16'd8, 16'd2, 16'd10}) begin
      errors++;
      $display("FAIL stats got=%0d/%0d/%0d %0d/%0d/%0d required 8/2/10", sa_g0, sa_g1, sa_c,
               sb_g0, sb_g1, sb_c);
    end
`endif
    tick();
    tick();
  endtask

  task automatic test_write_read();
    tick();
    set_port(1, 1'b1, 1'b1, 12'h020, 32'h12345678);
    @(negedge clock);
    checks++;
    if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt} !== 4'b0101) begin
      errors++;
      $display("FAIL write_gnt got=%b required 0101", {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt});
    end
    checks++;
    if ({wren_a, wren_b, addr_a, addr_b, data_a, data_b} !==
        {2'b11, 12'h020, 12'h020, 32'h12345678, 32'h12345678}) begin
      errors++;
      $display("FAIL write_mem wren=%b%b addr=%h/%h data=%h/%h required 11 020 12345678",
               wren_a, wren_b, addr_a, addr_b, data_a, data_b);
    end
    ref_mem[12'h020] = 32'h12345678;
    tick();
    set_port(1, 1'b0, 1'b0, 12'h0, 32'h0);
    set_port(0, 1'b1, 1'b0, 12'h020, 32'h0);
    @(negedge clock);
    checks++;
    if ({ia0.gnt, ia1.gnt, wren_a, wren_b} !== 4'b1000) begin
      errors++;
      $display("FAIL read_after_write gnt=%b%b wren=%b%b required gnt 10 wren 00",
               ia0.gnt, ia1.gnt, wren_a, wren_b);
    end
    push_read(0, 12'h020);
    tick();
    set_port(0, 1'b0, 1'b0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if ({wren_a, wren_b, ia0.gnt, ia1.gnt} !== 4'b0000) begin
      errors++;
      $display("FAIL idle_outputs wren=%b%b gnt=%b%b required 0", wren_a, wren_b,
               ia0.gnt, ia1.gnt);
    end
    tick();
    tick();
  endtask

  task automatic test_back_to_back();
    logic [11:0] addrs [3];
    bit          port;
    addrs[0] = 12'h001;
    addrs[1] = 12'h002;
    addrs[2] = 12'h003;
    for (int i = 0; i < 3; i++) begin
      port = (i == 1);
      tick();
      set_port(!port, 1'b0, 1'b0, 12'h0, 32'h0);
      set_port(port, 1'b1, 1'b0, addrs[i], 32'h0);
      @(negedge clock);
      checks++;
      if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt} !== {!port, port, !port, port}) begin
        errors++;
        $display("FAIL b2b_gnt step=%0d got=%b required %b", i,
                 {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt}, {!port, port, !port, port});
      end
      push_read(port, addrs[i]);
    end
    tick();
    set_port(0, 1'b0, 1'b0, 12'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    tick();
    set_port(0, 1'b1, 1'b0, 12'h010, 32'h0);
    set_port(1, 1'b1, 1'b0, 12'h002, 32'h0);
    @(negedge clock);
    checks++;
    if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt} !== 4'b1010) begin
      errors++;
      $display("FAIL mid_pre_gnt got=%b required 1010", {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt});
    end
    // Read granted but never queued: any return of it is flagged by the monitor.
    tick();
    reset = 1'b1;
    set_port(0, 1'b0, 1'b0, 12'h0, 32'h0);
    @(negedge clock);
    checks++;
    if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt, ia0.rvalid, ib0.rvalid, wren_a, wren_b} !== '0 ||
        {ia0.rdata, ia1.rdata, ib0.rdata, ib1.rdata, addr_a, addr_b, data_a, data_b} !== '0)
    begin
      errors++;
      $display("FAIL mid_reset_outputs gnt=%b rvalid=%b%b rdata=%h/%h required all 0",
               {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt}, ia0.rvalid, ib0.rvalid, ia0.rdata,
               ib0.rdata);
    end
    tick();
    tick();
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt} !== 4'b0101) begin
      errors++;
      $display("FAIL post_reset_gnt got=%b required 0101", {ia0.gnt, ia1.gnt, ib0.gnt, ib1.gnt});
    end
    push_read(1, 12'h002);
    tick();
    set_port(1, 1'b0, 1'b0, 12'h0, 32'h0);
    tick();
    tick();
    tick();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = init_val(12'(i));
    set_port(0, 1'b0, 1'b0, 12'h0, 32'h0);
    set_port(1, 1'b0, 1'b0, 12'h0, 32'h0);
    test_reset();
    test_single_read();
    test_starvation();
    test_write_read();
    test_back_to_back();
    test_reset_mid();
    @(negedge clock);
    checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      errors++;
      $display("FAIL pending_returns got=%0d/%0d required 0/0", qa.size(), qb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
